// File: rtl/hazard_ctrl_pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control slice.
// Contents:
//   - opcode and funct field constants used by the pipeline decode
//   - next-PC select encodings driven by the hazard controller
//   - state encoding for the multiply/divide sequencer FSM
//   - reg_match helper used by every hazard comparator
package mips_pipe_pkg;

  localparam logic [5:0] OP_R_FORMAT = 6'd0;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_ADDIU    = 6'd9;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;

  localparam logic [5:0] FN_NOP      = 6'd0;
  localparam logic [5:0] FN_MFHI     = 6'd16;
  localparam logic [5:0] FN_MFLO     = 6'd18;
  localparam logic [5:0] FN_MULTU    = 6'd25;
  localparam logic [5:0] FN_DIVU     = 6'd27;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JMP  = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A producer destination collides with the instruction in ID when it names
  // rs, or names rt and rt is actually read. Register $0 is hard-wired to
  // zero, so writes to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipeline_if.sv
// Bundle of the signals exchanged between the pipeline datapath and the
// hazard controller.
// Modports:
//   master - pipeline side: drives decoded ID info and EX/MEM destinations,
//            receives enables, flush, PC select, MD handshake and counter
//   slave  - hazard controller side (mirror of master)
// Parameter CNT_W sets the width of the stall_cycles counter.
interface hazard_ctrl_pipeline_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_jump;
  logic             id_taken;
  logic             id_md_start;
  logic             id_md_use;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_dst;
  logic             mem_mem_read;
  logic [4:0]       mem_dst;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             if_flush;
  logic [1:0]       pc_sel;
  logic             md_go;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch, id_jump, id_taken,
           id_md_start, id_md_use, ex_reg_write, ex_mem_read, ex_dst,
           mem_mem_read, mem_dst,
    input  pc_write, ifid_write, idex_bubble, if_flush, pc_sel,
           md_go, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch, id_jump, id_taken,
           id_md_start, id_md_use, ex_reg_write, ex_mem_read, ex_dst,
           mem_mem_read, mem_dst,
    output pc_write, ifid_write, idex_bubble, if_flush, pc_sel,
           md_go, md_busy, md_done, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_pipeline_md_seq.sv
// Sequencer for the multi-cycle MULTU/DIVU unit.
// Ports:
//   clk      - pipeline clock
//   rst      - synchronous active-high reset; also masks busy/done at once
//   start_ok - a MULTU/DIVU sits in ID and the pipeline is not stalled
//   md_go    - one-cycle start pulse to the MD unit
//   md_busy  - MD unit is executing (MD_CYCLES cycles after md_go)
//   md_done  - high in the last busy cycle
module md_seq
  import mips_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_ok,
  output logic md_go,
  output logic md_busy,
  output logic md_done
);

  localparam int CW = 6;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and output decode. The counter is loaded with MD_CYCLES-1 on
  // the go cycle and busy ends on the cycle where it reads zero, so busy spans
  // exactly MD_CYCLES cycles. Busy and done are masked by reset so that a
  // reset in the middle of an operation drops them in the same cycle and no
  // done pulse escapes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_go   = 1'b0;
    md_busy = (state_q == MD_BUSY) && !rst;
    md_done = md_busy && (cnt_q == '0);
    case (state_q)
      MD_IDLE: begin
        if (start_ok && !rst) begin
          md_go   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // State and latency counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl_pipeline.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Ports:
//   clk - pipeline clock
//   rst - synchronous active-high reset
//   bus - hazard_ctrl_pipeline_if.slave: decoded ID control, EX/MEM
//         destinations in; PC/IF-ID/ID-EX enables, IF flush, next-PC select,
//         MD go/busy/done and the saturating stall_cycles counter out
// All enable/flush/select outputs are combinational so a hazard is acted on
// in the very cycle it appears in ID.
module hazard_ctrl_pipeline
  import mips_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_ctrl_pipeline_if.slave bus
);

  logic             br;
  logic             ex_match;
  logic             mem_match;
  logic             load_use;
  logic             br_alu;
  logic             br_load;
  logic             data_stall;
  logic             md_stall;
  logic             stall;
  logic             start_ok;
  logic             md_go;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hazard detection. A BEQ resolves in ID, so it needs its operands one
  // stage earlier than an ALU consumer: an ALU result in EX costs one stall,
  // and a load costs two (load-use first, then branch-load from MEM). A jump
  // also raises id_branch, so br excludes it from the branch hazards.
  always_comb begin
    br         = bus.id_branch && !bus.id_jump;
    ex_match   = reg_match(bus.ex_dst, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    mem_match  = reg_match(bus.mem_dst, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    load_use   = bus.ex_mem_read && ex_match;
    br_alu     = br && bus.ex_reg_write && ex_match;
    br_load    = br && bus.mem_mem_read && mem_match;
    data_stall = load_use || br_alu || br_load;
    md_stall   = md_busy && (bus.id_md_use || bus.id_md_start);
    stall      = data_stall || md_stall;
    start_ok   = bus.id_md_start && !stall;
  end

  md_seq #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .start_ok (start_ok),
    .md_go    (md_go),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  // Pipeline control with priority reset > stall > jump > branch. During a
  // stall any jump or branch in ID is ignored; it stays in ID and is looked
  // at again next cycle. Reset holds the front end frozen and flushes IF/ID.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.if_flush    = 1'b0;
    bus.pc_sel      = PC_SEL_SEQ;
    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      bus.if_flush    = 1'b1;
    end else if (stall) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end else if (bus.id_branch && bus.id_jump) begin
      bus.pc_sel   = PC_SEL_JMP;
      bus.if_flush = 1'b1;
    end else if (br && bus.id_taken) begin
      bus.pc_sel   = PC_SEL_BR;
      bus.if_flush = 1'b1;
    end
  end

  // MD handshake is passed straight through from the sequencer.
  always_comb begin
    bus.md_go   = md_go;
    bus.md_busy = md_busy;
    bus.md_done = md_done;
  end

  // Stall-cycle performance counter. It sticks at all-ones rather than
  // wrapping so that a long run never reports a misleadingly small value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    bus.stall_cycles = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipeline.sv
// Directed testbench for hazard_ctrl_pipeline.
// A main instance (MD_CYCLES=32, CNT_W=32) covers hazards, branches, jumps
// and the MD sequencer; a second instance with CNT_W=4 covers counter
// saturation. Inputs change 1 ns after the rising edge and outputs are
// sampled 1 ns later, well away from the active edge.
module tb_hazard_ctrl_pipeline;

  import mips_pipe_pkg::*;

  // Control vector order: {pc_write, ifid_write, idex_bubble, if_flush, pc_sel}
  localparam logic [5:0] V_NORMAL = 6'b110000;
  localparam logic [5:0] V_STALL  = 6'b001000;
  localparam logic [5:0] V_BRANCH = 6'b110101;
  localparam logic [5:0] V_JUMP   = 6'b110110;
  localparam logic [5:0] V_RESET  = 6'b001100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_pipeline_if #(.CNT_W(32)) bus ();
  hazard_ctrl_pipeline_if #(.CNT_W(4))  bus4 ();

  logic [5:0] ctrl_vec;
  logic [5:0] ctrl4_vec;

  assign ctrl_vec  = {bus.pc_write, bus.ifid_write, bus.idex_bubble,
                      bus.if_flush, bus.pc_sel};
  assign ctrl4_vec = {bus4.pc_write, bus4.ifid_write, bus4.idex_bubble,
                      bus4.if_flush, bus4.pc_sel};

  hazard_ctrl_pipeline #(.MD_CYCLES(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_ctrl_pipeline #(.MD_CYCLES(32), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Drive every DUT input of both instances to an idle (nop) pattern
  task automatic clear_inputs();
    bus.id_rs = 5'd0;        bus.id_rt = 5'd0;        bus.id_uses_rt = 1'b0;
    bus.id_branch = 1'b0;    bus.id_jump = 1'b0;      bus.id_taken = 1'b0;
    bus.id_md_start = 1'b0;  bus.id_md_use = 1'b0;    bus.ex_reg_write = 1'b0;
    bus.ex_mem_read = 1'b0;  bus.ex_dst = 5'd0;       bus.mem_mem_read = 1'b0;
    bus.mem_dst = 5'd0;
    bus4.id_rs = 5'd0;       bus4.id_rt = 5'd0;       bus4.id_uses_rt = 1'b0;
    bus4.id_branch = 1'b0;   bus4.id_jump = 1'b0;     bus4.id_taken = 1'b0;
    bus4.id_md_start = 1'b0; bus4.id_md_use = 1'b0;   bus4.ex_reg_write = 1'b0;
    bus4.ex_mem_read = 1'b0; bus4.ex_dst = 5'd0;      bus4.mem_mem_read = 1'b0;
    bus4.mem_dst = 5'd0;
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, leaving rst low 1 ns after an edge
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset overrides every ID request; outputs come back clean afterwards
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.id_md_start = 1'b1;
    bus.id_branch = 1'b1;
    bus.id_jump = 1'b1;
    step();
    #1;
    checks++; if (ctrl_vec !== V_RESET) begin errors++; $display("[TB] FAIL reset_ctrl got=%b want=%b", ctrl_vec, V_RESET); end
    checks++; if (bus.md_go !== 1'b0) begin errors++; $display("[TB] FAIL reset_md_go got=%b want=0", bus.md_go); end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_md_busy got=%b want=0", bus.md_busy); end
    checks++; if (bus.md_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_md_done got=%b want=0", bus.md_done); end
    checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d want=0", bus.stall_cycles); end
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL reset_after_ctrl got=%b want=%b", ctrl_vec, V_NORMAL); end
  endtask

  // lw $2,0($1) then add $3,$2,$4
  task automatic test_load_use();
    do_reset();
    bus.id_rs = 5'd2; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL load_use_stall got=%b want=%b", ctrl_vec, V_STALL); end
    step();
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = 5'd0;
    bus.mem_mem_read = 1'b1; bus.mem_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL load_use_release got=%b want=%b", ctrl_vec, V_NORMAL); end
    checks++; if (bus.stall_cycles !== 32'd1) begin errors++; $display("[TB] FAIL load_use_count got=%0d want=1", bus.stall_cycles); end
    clear_inputs();
  endtask

  // add $2,$5,$6 then beq $2,$3 (taken)
  task automatic test_branch_alu();
    do_reset();
    bus.id_rs = 5'd2; bus.id_rt = 5'd3; bus.id_uses_rt = 1'b1;
    bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL br_alu_stall got=%b want=%b", ctrl_vec, V_STALL); end
    step();
    bus.ex_reg_write = 1'b0; bus.ex_dst = 5'd0;
    bus.mem_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_BRANCH) begin errors++; $display("[TB] FAIL br_alu_taken got=%b want=%b", ctrl_vec, V_BRANCH); end
    checks++; if (bus.stall_cycles !== 32'd1) begin errors++; $display("[TB] FAIL br_alu_count got=%0d want=1", bus.stall_cycles); end
    clear_inputs();
  endtask

  // lw $2,0($1) then beq $3,$2 (taken): two stalls then redirect
  task automatic test_branch_load();
    do_reset();
    bus.id_rs = 5'd3; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b1;
    bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL br_load_stall1 got=%b want=%b", ctrl_vec, V_STALL); end
    step();
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = 5'd0;
    bus.mem_mem_read = 1'b1; bus.mem_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL br_load_stall2 got=%b want=%b", ctrl_vec, V_STALL); end
    step();
    bus.mem_mem_read = 1'b0; bus.mem_dst = 5'd0;
    #1;
    checks++; if (ctrl_vec !== V_BRANCH) begin errors++; $display("[TB] FAIL br_load_taken got=%b want=%b", ctrl_vec, V_BRANCH); end
    checks++; if (bus.stall_cycles !== 32'd2) begin errors++; $display("[TB] FAIL br_load_count got=%0d want=2", bus.stall_cycles); end
    clear_inputs();
  endtask

  // Unhazarded beq taken / not taken, j, and a jump held off by a stall
  task automatic test_branch_jump();
    do_reset();
    bus.id_rs = 5'd1; bus.id_rt = 5'd1; bus.id_uses_rt = 1'b1;
    bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    #1;
    checks++; if (ctrl_vec !== V_BRANCH) begin errors++; $display("[TB] FAIL beq_taken got=%b want=%b", ctrl_vec, V_BRANCH); end
    step();
    bus.id_uses_rt = 1'b0; bus.id_jump = 1'b1; bus.id_taken = 1'b0;
    #1;
    checks++; if (ctrl_vec !== V_JUMP) begin errors++; $display("[TB] FAIL jump got=%b want=%b", ctrl_vec, V_JUMP); end
    bus.id_taken = 1'b1;
    #1;
    checks++; if (ctrl_vec !== V_JUMP) begin errors++; $display("[TB] FAIL jump_over_branch got=%b want=%b", ctrl_vec, V_JUMP); end
    step();
    bus.id_jump = 1'b0; bus.id_taken = 1'b0; bus.id_uses_rt = 1'b1;
    #1;
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL beq_not_taken got=%b want=%b", ctrl_vec, V_NORMAL); end
    step();
    bus.id_jump = 1'b1; bus.id_rs = 5'd5; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd5;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL jump_in_stall got=%b want=%b", ctrl_vec, V_STALL); end
    clear_inputs();
  endtask

  // $0 never hazards; rt only matters when it is read
  task automatic test_zero_reg();
    do_reset();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd0;
    #1;
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL zero_reg got=%b want=%b", ctrl_vec, V_NORMAL); end
    step();
    bus.id_rs = 5'd1; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b0; bus.ex_dst = 5'd7;
    #1;
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL rt_unused got=%b want=%b", ctrl_vec, V_NORMAL); end
    step();
    checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL zero_reg_count got=%0d want=0", bus.stall_cycles); end
    clear_inputs();
  endtask

  // divu (held one cycle by a load-use), addiu, mflo, then a second divu
  task automatic test_md();
    do_reset();
    bus.id_rs = 5'd2; bus.id_rt = 5'd3; bus.id_uses_rt = 1'b1; bus.id_md_start = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd2;
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL md_blocked_ctrl got=%b want=%b", ctrl_vec, V_STALL); end
    checks++; if (bus.md_go !== 1'b0) begin errors++; $display("[TB] FAIL md_blocked_go got=%b want=0", bus.md_go); end
    step();
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = 5'd0;
    bus.mem_mem_read = 1'b1; bus.mem_dst = 5'd2;
    #1;
    checks++; if (bus.md_go !== 1'b1) begin errors++; $display("[TB] FAIL md_go got=%b want=1", bus.md_go); end
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("[TB] FAIL md_go_busy got=%b want=0", bus.md_busy); end
    step();
    clear_inputs();
    bus.id_rs = 5'd1;
    #1;
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL md_addiu got=%b want=%b", ctrl_vec, V_NORMAL); end
    checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("[TB] FAIL md_busy1 got=%b want=1", bus.md_busy); end
    checks++; if (bus.md_go !== 1'b0) begin errors++; $display("[TB] FAIL md_go_busy1 got=%b want=0", bus.md_go); end
    step();
    bus.id_rs = 5'd0; bus.id_md_use = 1'b1;
    for (int i = 2; i <= 32; i++) begin
      #1;
      checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL mflo_stall cycle=%0d got=%b want=%b", i, ctrl_vec, V_STALL); end
      checks++; if (bus.md_done !== (i == 32)) begin errors++; $display("[TB] FAIL md_done cycle=%0d got=%b want=%b", i, bus.md_done, (i == 32)); end
      step();
    end
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("[TB] FAIL md_busy_end got=%b want=0", bus.md_busy); end
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL mflo_issue got=%b want=%b", ctrl_vec, V_NORMAL); end
    checks++; if (bus.stall_cycles !== 32'd32) begin errors++; $display("[TB] FAIL md_count got=%0d want=32", bus.stall_cycles); end
    step();
    bus.id_md_use = 1'b0; bus.id_md_start = 1'b1;
    #1;
    checks++; if (bus.md_go !== 1'b1) begin errors++; $display("[TB] FAIL md_go2 got=%b want=1", bus.md_go); end
    step();
    #1;
    checks++; if (ctrl_vec !== V_STALL) begin errors++; $display("[TB] FAIL divu_in_busy got=%b want=%b", ctrl_vec, V_STALL); end
    checks++; if (bus.md_go !== 1'b0) begin errors++; $display("[TB] FAIL md_go_in_busy got=%b want=0", bus.md_go); end
    step();
    checks++; if (bus.stall_cycles !== 32'd33) begin errors++; $display("[TB] FAIL md_count2 got=%0d want=33", bus.stall_cycles); end
    clear_inputs();
  endtask

  // Reset on busy cycle 10 aborts the operation; a new divu runs the full count
  task automatic test_md_reset();
    int busy_n;
    int done_n;
    int done_at;
    logic done_seen;
    do_reset();
    bus.id_md_start = 1'b1;
    #1;
    checks++; if (bus.md_go !== 1'b1) begin errors++; $display("[TB] FAIL rst_md_go got=%b want=1", bus.md_go); end
    step();
    clear_inputs();
    for (int i = 1; i < 10; i++) step();
    #1;
    checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy10 got=%b want=1", bus.md_busy); end
    rst = 1'b1;
    bus.id_md_use = 1'b1;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_abort_busy got=%b want=0", bus.md_busy); end
    checks++; if (ctrl_vec !== V_RESET) begin errors++; $display("[TB] FAIL rst_abort_ctrl got=%b want=%b", ctrl_vec, V_RESET); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_busy got=%b want=0", bus.md_busy); end
    checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL rst_after_count got=%0d want=0", bus.stall_cycles); end
    checks++; if (ctrl_vec !== V_NORMAL) begin errors++; $display("[TB] FAIL rst_no_stall got=%b want=%b", ctrl_vec, V_NORMAL); end
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.md_done !== 1'b0) done_seen = 1'b1;
      step();
    end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_done got=%b want=0", done_seen); end
    clear_inputs();
    bus.id_md_start = 1'b1;
    #1;
    checks++; if (bus.md_go !== 1'b1) begin errors++; $display("[TB] FAIL restart_go got=%b want=1", bus.md_go); end
    step();
    clear_inputs();
    busy_n = 0;
    done_n = 0;
    done_at = 0;
    while (bus.md_busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (bus.md_done === 1'b1) begin
        done_n++;
        done_at = busy_n;
      end
      step();
    end
    checks++; if (busy_n != 32) begin errors++; $display("[TB] FAIL restart_busy_len got=%0d want=32", busy_n); end
    checks++; if (done_n != 1 || done_at != 32) begin errors++; $display("[TB] FAIL restart_done got=%0d pulses at %0d want=1 at 32", done_n, done_at); end
  endtask

  // CNT_W=4 instance held in stall: counter stops at 15
  task automatic test_saturation();
    do_reset();
    bus4.id_rs = 5'd5; bus4.ex_mem_read = 1'b1; bus4.ex_dst = 5'd5;
    #1;
    checks++; if (ctrl4_vec !== V_STALL) begin errors++; $display("[TB] FAIL sat_stall got=%b want=%b", ctrl4_vec, V_STALL); end
    for (int i = 0; i < 14; i++) step();
    checks++; if (bus4.stall_cycles !== 4'd14) begin errors++; $display("[TB] FAIL sat_count14 got=%0d want=14", bus4.stall_cycles); end
    step();
    checks++; if (bus4.stall_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_count15 got=%0d want=15", bus4.stall_cycles); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus4.stall_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_hold got=%0d want=15", bus4.stall_cycles); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_branch_jump();
    test_zero_reg();
    test_md();
    test_md_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_pipeline.md
Name: hazard_ctrl_pipeline

Overview:
Stall/flush controller for the 5-stage MIPS pipeline. It consumes decoded ID-stage control from the pipeline control unit plus EX/MEM destination info, and drives the PC, IF/ID and ID/EX enables, the next-PC select and the IF flush. It also sequences the multi-cycle MULTU/DIVU unit: it issues the start pulse, counts latency, and stalls HI/LO consumers. It keeps a saturating stall-cycle performance counter.

Parameters:
MD_CYCLES, 32, busy cycles of the multiply/divide unit after start (legal 1..63)
CNT_W, 32, width of the stall_cycles counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  rt is a source operand (R-format, BEQ, SW)
id_branch  in  1  Branch from control unit (high for BEQ and J)
id_jump  in  1  Jump from control unit
id_taken  in  1  ID-stage register comparator equal
id_md_start  in  1  ID holds MULTU/DIVU
id_md_use  in  1  ID holds MFHI/MFLO
ex_reg_write  in  1  ID/EX RegWrite
ex_mem_read  in  1  ID/EX MemRead
ex_dst  in  5  ID/EX destination register (after RegDst mux)
mem_mem_read  in  1  EX/MEM MemRead
mem_dst  in  5  EX/MEM destination register
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_bubble  out  1  force ID/EX control bits to zero
if_flush  out  1  squash the instruction in IF/ID
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
md_go  out  1  one-cycle start pulse to the MD unit
md_busy  out  1  MD unit is executing
md_done  out  1  high in the last busy cycle
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Register matches ignore $0: a destination of 0 never causes a hazard.
- match(d) = (d==id_rs) | (id_uses_rt & d==id_rt).
- Condition br = id_branch & ~id_jump.
- Load-use hazard: ex_mem_read & match(ex_dst).
- Branch-ALU hazard: br & ex_reg_write & match(ex_dst). Gives one stall.
- Branch-load hazard: br & mem_mem_read & match(mem_dst). Together with load-use this gives two stalls for lw followed by beq.
- data_stall = OR of the three hazards.
- md_stall = md_busy & (id_md_use | id_md_start).
- stall = data_stall | md_stall.
- Stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0, pc_sel=00.
- Priority is stall > jump > branch. A branch or jump in ID during a stall is not acted on; it is re-evaluated on the next cycle.
- No stall, id_branch & id_jump: pc_sel=10, if_flush=1 for one cycle, id_taken ignored.
- No stall, br & id_taken: pc_sel=01, if_flush=1.
- Otherwise: pc_write=1, ifid_write=1, idex_bubble=0, if_flush=0, pc_sel=00.
- All hazard and flush outputs are combinational from the inputs and the MD state, so they have zero latency.
- MD FSM states are IDLE and BUSY.
  - IDLE: if id_md_start & ~stall, then md_go=1 that cycle, cnt<=MD_CYCLES-1, next state BUSY.
  - BUSY: md_busy=1. If cnt==0, md_done=1 and next state is IDLE; otherwise cnt decrements.
  - BUSY therefore lasts exactly MD_CYCLES cycles after the md_go cycle.
  - An MFHI/MFLO in ID during the md_done cycle still stalls; it issues on the following cycle.
- md_go never asserts while BUSY or while stalled. A start blocked by data_stall issues on the first unstalled cycle.
- stall_cycles increments by 1 on every cycle with stall=1 and rst=0. It saturates at all-ones and never wraps.
- While rst is high:
  - pc_write=0, ifid_write=0, idex_bubble=1, if_flush=1, pc_sel=00, md_go=0.
  - Registered state clears: FSM=IDLE, cnt=0, stall_cycles=0.
  - On the cycle after rst falls, md_busy=0 and md_done=0.
- Reset mid-operation aborts BUSY immediately: no md_done is produced and no stall persists.
- Unknown inputs (the control unit outputs x on undefined opcodes) are not filtered; the bench drives only legal encodings.

Decomposition:
- Shared package mips_pipe_pkg:
  - opcode constants R_FORMAT=0, J=2, BEQ=4, ADDIU=9, LW=35, SW=43
  - funct constants NOP=0, MFHI=16, MFLO=18, MULTU=25, DIVU=27
  - PC_SEL_SEQ/BR/JMP encodings
  - MD FSM state encoding
- One sub-module, md_seq: the IDLE/BUSY FSM plus latency counter. It has inputs start_ok and rst, and outputs md_go, md_busy and md_done.
- The hazard comparators and the stall counter stay in the top level.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 -> exactly 1 cycle with pc_write=0/ifid_write=0/idex_bubble=1; stall_cycles=1.
- add $2,$5,$6 then beq $2,$3 -> 1 stall. lw $2,0($1) then beq $2,$3 -> 2 consecutive stalls, then pc_sel=01 and if_flush=1 if equal.
- beq taken with no hazard -> pc_sel=01, if_flush=1 for 1 cycle. j with id_taken=0 -> pc_sel=10, if_flush=1. beq not taken -> pc_sel=00, if_flush=0.
- divu, addiu, mflo with MD_CYCLES=32:
  - md_go for 1 cycle, then md_busy for 32 cycles, with md_done on the 32nd.
  - addiu is not stalled.
  - mflo stalls until the cycle after md_done.
  - A second divu in BUSY also stalls.
- rst asserted on busy cycle 10 -> the next cycle shows md_busy=0, stall_cycles=0, and md_done never pulses. A following divu restarts the full 32-cycle count.
- lw $0,0($1) then add $3,$0,$0 -> no stall. A forced stall run with CNT_W=4 over 20 cycles -> stall_cycles holds at 15.
